// File: rtl/nvr_fetch_unit.sv
// nvr_fetch_unit: read sequencer for the NVR_TOP instruction memory macro.
// It runs the macro power-on sequence, turns valid/ready fetch requests into
// A/CE timing, waits for a synchronised RDY (with timeout), and buffers the
// results in a small first-word fall-through response FIFO that can be flushed.
module nvr_fetch_unit #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned CE_CYCLES    = 2,
    parameter int unsigned POR_CYCLES   = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] nvr_a,
    output logic              nvr_ce,
    output logic              nvr_por,
    input  logic [DATA_W-1:0] nvr_dout,
    input  logic              nvr_rdy,
    output logic              busy
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CNT_MAX = max2(max2(POR_CYCLES, TIMEOUT),
                                           max2(SETUP_CYCLES, CE_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]  POR_ON_LAST   = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0]  POR_WAIT_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST    = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CE_LAST       = CNT_W'(CE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL     = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        POR_ON,
        POR_WAIT,
        IDLE,
        SETUP,
        CE_ON,
        WAIT_RDY
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              rdy_meta;
    logic              rdy_s;
    logic              drop;
    logic              in_flight;
    logic              accept;
    logic              complete;
    logic              complete_err;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic              fifo_err  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;

    // Two-flop synchroniser for the asynchronous macro RDY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= nvr_rdy;
            rdy_s    <= rdy_meta;
        end
    end

    // State and cycle-counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= POR_ON;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and handshake decode.
    // POR_ON is already the state while reset is held, so its counter ends one
    // value later than the others to give exactly POR_CYCLES of nvr_por high.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        req_ready    = 1'b0;
        accept       = 1'b0;
        complete     = 1'b0;
        complete_err = 1'b0;
        case (state)
            POR_ON: begin
                if (cnt == POR_ON_LAST) begin
                    state_next = POR_WAIT;
                    cnt_next   = '0;
                end
            end
            POR_WAIT: begin
                if (cnt == POR_WAIT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                cnt_next  = '0;
                req_ready = (fifo_count < FIFO_FULL) && !flush;
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = CE_ON;
                    cnt_next   = '0;
                end
            end
            CE_ON: begin
                if (cnt == CE_LAST) begin
                    state_next = WAIT_RDY;
                    cnt_next   = '0;
                end
            end
            WAIT_RDY: begin
                if (rdy_s) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    complete     = 1'b1;
                    complete_err = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = '0;
                end
            end
            default: begin
                state_next = POR_ON;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign in_flight = (state == SETUP) || (state == CE_ON) || (state == WAIT_RDY);

    // Registered macro controls, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nvr_ce  <= 1'b0;
            nvr_por <= 1'b0;
        end else begin
            nvr_ce  <= (state_next == CE_ON);
            nvr_por <= (state_next == POR_ON);
        end
    end

    // Macro address: captured on accept, held until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nvr_a <= '0;
        end else if (accept) begin
            nvr_a <= req_addr;
        end
    end

    // Drop flag: a flush during an access suppresses that access's result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (complete) begin
            drop <= 1'b0;
        end else if (flush && in_flight) begin
            drop <= 1'b1;
        end
    end

    assign push      = complete && !drop && !flush;
    assign pop       = rsp_valid && rsp_ready;
    assign push_data = complete_err ? '0 : nvr_dout;

    // Response FIFO storage; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_addr[wr_ptr] <= nvr_a;
            fifo_err[wr_ptr]  <= complete_err;
        end
    end

    // Response FIFO pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr] : '0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_nvr_fetch_unit.sv
// Self-checking bench for nvr_fetch_unit: directed scenarios for POR timing,
// read latency, back-pressure, timeout, flush and mid-access reset, plus a
// randomized phase checked against a transaction-level reference model.
module tb_nvr_fetch_unit;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 2;
    localparam int LAT     = 5;    // accept edge to push edge with RDY high
    localparam int TO_LAT  = 259;  // accept edge to timeout push edge

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              flush = 1'b0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              rsp_ready = 1'b0;
    logic [ADDR_W-1:0] nvr_a;
    logic              nvr_ce;
    logic              nvr_por;
    logic [DATA_W-1:0] nvr_dout;
    logic              nvr_rdy = 1'b0;
    logic              busy;

    logic [DATA_W-1:0] macro_mem [128];
    assign nvr_dout = macro_mem[nvr_a];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    nvr_fetch_unit #(
        .ADDR_W      (7),
        .DATA_W      (32),
        .SETUP_CYCLES(2),
        .CE_CYCLES   (2),
        .POR_CYCLES  (4),
        .TIMEOUT     (255),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rsp_err  (rsp_err),
        .rsp_ready(rsp_ready),
        .nvr_a    (nvr_a),
        .nvr_ce   (nvr_ce),
        .nvr_por  (nvr_por),
        .nvr_dout (nvr_dout),
        .nvr_rdy  (nvr_rdy),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for req_ready, then present one request for one edge.
    task automatic issue(input logic [ADDR_W-1:0] a, input string tag);
        int i;
        for (i = 0; i < 600 && !req_ready; i++) step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: req_ready=%b expected 1 within 600 cycles", tag, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Called just after reset release: POR high 4 cycles, low 4, then ready.
    task automatic check_por_sequence(input string tag);
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (nvr_por !== (k <= 4)) begin
                errors++;
                $display("FAIL %s_por_k%0d: nvr_por=%b expected %b", tag, k, nvr_por, (k <= 4));
            end
            checks++;
            if (nvr_ce !== 1'b0) begin
                errors++;
                $display("FAIL %s_ce_k%0d: nvr_ce=%b expected 0", tag, k, nvr_ce);
            end
            checks++;
            if (req_ready !== (k >= 9)) begin
                errors++;
                $display("FAIL %s_ready_k%0d: req_ready=%b expected %b", tag, k, req_ready, (k >= 9));
            end
        end
    endtask

    task automatic test_reset();
        nvr_rdy = 1'b1;
        step();
        step();
        checks++;
        if ({nvr_por, nvr_ce, req_ready, rsp_valid, busy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: por/ce/ready/valid/busy=%b expected 00001",
                     {nvr_por, nvr_ce, req_ready, rsp_valid, busy});
        end
        checks++;
        if ({nvr_a, rsp_data, rsp_addr, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_zero: nvr_a=%h rsp_data=%h rsp_addr=%h rsp_err=%b expected 0",
                     nvr_a, rsp_data, rsp_addr, rsp_err);
        end
        reset = 1'b0;
        check_por_sequence("por");
    endtask

    task automatic test_single_read();
        macro_mem[5] = 32'hDEADBEEF;
        issue(7'd5, "single");
        for (int k = 1; k <= LAT; k++) begin
            step();
            checks++;
            if (nvr_ce !== (k == 2 || k == 3)) begin
                errors++;
                $display("FAIL single_ce_k%0d: nvr_ce=%b expected %b", k, nvr_ce, (k == 2 || k == 3));
            end
            checks++;
            if (rsp_valid !== (k >= LAT)) begin
                errors++;
                $display("FAIL single_valid_k%0d: rsp_valid=%b expected %b", k, rsp_valid, (k >= LAT));
            end
            checks++;
            if (nvr_a !== 7'd5) begin
                errors++;
                $display("FAIL single_addr_k%0d: nvr_a=%h expected 05", k, nvr_a);
            end
        end
        checks++;
        if (rsp_data !== 32'hDEADBEEF || rsp_addr !== 7'd5 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: data=%h addr=%h err=%b expected deadbeef 05 0",
                     rsp_data, rsp_addr, rsp_err);
        end
        pop_one();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] pending[$];
        logic [ADDR_W-1:0] got[$];
        logic [DATA_W-1:0] got_d[$];
        int n_acc;
        logic acc;
        pending = '{7'd1, 7'd2, 7'd3};
        n_acc = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            req_valid = (pending.size() > 0);
            if (pending.size() > 0) req_addr = pending[0];
            acc = req_valid && req_ready;
            step();
            if (acc) begin
                void'(pending.pop_front());
                n_acc++;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (n_acc !== 2) begin
            errors++;
            $display("FAIL bp_accepts: accepted=%0d expected 2", n_acc);
        end
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 7'd1) begin
            errors++;
            $display("FAIL bp_full: req_ready=%b rsp_valid=%b rsp_addr=%h expected 0 1 01",
                     req_ready, rsp_valid, rsp_addr);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && got.size() < 3; i++) begin
            req_valid = (pending.size() > 0);
            if (pending.size() > 0) req_addr = pending[0];
            acc = req_valid && req_ready;
            if (rsp_valid) begin
                got.push_back(rsp_addr);
                got_d.push_back(rsp_data);
            end
            step();
            if (acc) void'(pending.pop_front());
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (got.size() !== 3) begin
            errors++;
            $display("FAIL bp_count: popped=%0d expected 3", got.size());
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== 7'(i + 1) || got_d[i] !== macro_mem[i + 1]) begin
                errors++;
                $display("FAIL bp_order%0d: addr=%h data=%h expected %h %h",
                         i, got[i], got_d[i], 7'(i + 1), macro_mem[i + 1]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [ADDR_W-1:0] addrs [2];
        addrs[0] = 7'd9;
        addrs[1] = 7'd40;
        nvr_rdy = 1'b0;
        step(); step(); step();
        for (int t = 0; t < 2; t++) begin
            issue(addrs[t], "timeout");
            for (int k = 1; k <= TO_LAT; k++) begin
                step();
                if (k == TO_LAT - 1) begin
                    checks++;
                    if (rsp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout%0d_early: rsp_valid=%b expected 0 at E%0d", t, rsp_valid, k);
                    end
                end
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_addr !== addrs[t]) begin
                errors++;
                $display("FAIL timeout%0d_rsp: valid=%b err=%b data=%h addr=%h expected 1 1 0 %h",
                         t, rsp_valid, rsp_err, rsp_data, rsp_addr, addrs[t]);
            end
            pop_one();
        end
        nvr_rdy = 1'b1;
        step(); step(); step();
        issue(7'd41, "after_timeout");
        for (int k = 1; k <= LAT; k++) step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== macro_mem[41] || rsp_addr !== 7'd41) begin
            errors++;
            $display("FAIL timeout_recover: valid=%b err=%b data=%h addr=%h expected 1 0 %h 29",
                     rsp_valid, rsp_err, rsp_data, rsp_addr, macro_mem[41]);
        end
        pop_one();
    endtask

    task automatic test_flush();
        int ce_high;
        issue(7'd10, "flush_pre");
        for (int k = 1; k <= LAT; k++) step();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_buffered: rsp_valid=%b expected 1", rsp_valid);
        end
        issue(7'd11, "flush_inflight");
        ce_high = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (nvr_ce) ce_high++;
            if (k == 2) flush = 1'b1;
            if (k == 3) flush = 1'b0;
            if (k >= 3) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_empty_k%0d: rsp_valid=%b expected 0", k, rsp_valid);
                end
            end
        end
        checks++;
        if (ce_high !== 2) begin
            errors++;
            $display("FAIL flush_ce_width: ce cycles=%0d expected 2", ce_high);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b expected 0", busy);
        end
        issue(7'd12, "flush_post");
        for (int k = 1; k <= LAT; k++) step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== macro_mem[12] || rsp_addr !== 7'd12) begin
            errors++;
            $display("FAIL flush_next: valid=%b err=%b data=%h addr=%h expected 1 0 %h 0c",
                     rsp_valid, rsp_err, rsp_data, rsp_addr, macro_mem[12]);
        end
        pop_one();
    endtask

    task automatic test_reset_mid_access();
        issue(7'd19, "rstmid_pre");
        for (int k = 1; k <= LAT; k++) step();
        issue(7'd20, "rstmid_access");
        step();
        step();
        checks++;
        if (nvr_ce !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: nvr_ce=%b rsp_valid=%b expected 1 1", nvr_ce, rsp_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (nvr_ce !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || nvr_por !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: ce=%b valid=%b busy=%b por=%b expected 0 0 1 0",
                     nvr_ce, rsp_valid, busy, nvr_por);
        end
        step();
        reset = 1'b0;
        check_por_sequence("rstmid");
        issue(7'd21, "rstmid_post");
        for (int k = 1; k <= LAT; k++) step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== macro_mem[21] || rsp_addr !== 7'd21) begin
            errors++;
            $display("FAIL rstmid_read: valid=%b data=%h addr=%h expected 1 %h 15",
                     rsp_valid, rsp_data, rsp_addr, macro_mem[21]);
        end
        pop_one();
    endtask

    // Transaction-level model: each accepted request yields one response LAT
    // edges later; responses pop in order; a flush discards every outstanding
    // request; only one request may be in flight and at most DEPTH outstanding.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                done;
    } exp_t;

    task automatic test_random();
        exp_t q[$];
        int last_acc;
        int n;
        logic acc, pop, exp_busy, exp_ready, exp_valid;
        last_acc = cyc - 100;
        for (int it = 0; it < 500; it++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = 7'($urandom_range(0, 127));
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            n = cyc;
            exp_busy  = (n - last_acc) < LAT;
            exp_ready = !flush && !exp_busy && (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && (q[0].done <= n);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready_it%0d: req_ready=%b expected %b", it, req_ready, exp_ready);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_busy_it%0d: busy=%b expected %b", it, busy, exp_busy);
            end
            checks++;
            if (rsp_valid !== exp_valid) begin
                errors++;
                $display("FAIL rand_valid_it%0d: rsp_valid=%b expected %b", it, rsp_valid, exp_valid);
            end
            if (rsp_valid && q.size() > 0) begin
                checks++;
                if (rsp_addr !== q[0].addr || rsp_data !== macro_mem[q[0].addr] || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_head_it%0d: addr=%h data=%h err=%b expected %h %h 0",
                             it, rsp_addr, rsp_data, rsp_err, q[0].addr, macro_mem[q[0].addr]);
                end
            end
            acc = req_valid && req_ready;
            pop = rsp_valid && rsp_ready;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (pop && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back('{addr: req_addr, done: n + 1 + LAT});
            end
            if (acc) last_acc = n + 1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) macro_mem[i] = $urandom();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nvr_fetch_unit.md
Name: nvr_fetch_unit

Overview:
Parametrised read sequencer for the NVR_TOP instruction memory macro. It replaces bench-driven CE pulsing with a synthesizable engine in front of the Controller.
- Runs the macro power-on (POR) sequence.
- Accepts fetch requests by valid/ready handshake and generates the A/CE timing.
- Waits for a synchronised RDY, with a timeout.
- Buffers results in a small response FIFO with flush support.

Parameters:
ADDR_W, 7, macro word-address width
DATA_W, 32, instruction/data width
SETUP_CYCLES, 2, cycles nvr_a is stable before nvr_ce rises (>=1)
CE_CYCLES, 2, nvr_ce high width in cycles (>=1)
POR_CYCLES, 4, nvr_por high width and post-POR settle time in cycles (>=1)
TIMEOUT, 255, max WAIT_RDY cycles before error completion (>=1)
FIFO_DEPTH, 2, response FIFO entries (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  fetch request valid
req_addr  in  ADDR_W  fetch word address
req_ready  out  1  request accepted when req_valid&&req_ready at rising edge
flush  in  1  discard buffered and in-flight responses
rsp_valid  out  1  FIFO head valid
rsp_data  out  DATA_W  FIFO head data
rsp_addr  out  ADDR_W  address of FIFO head
rsp_err  out  1  FIFO head completed by timeout
rsp_ready  in  1  consumer pops head when rsp_valid&&rsp_ready
nvr_a  out  ADDR_W  macro address
nvr_ce  out  1  macro chip enable, registered
nvr_por  out  1  macro power-on reset pulse, registered
nvr_dout  in  DATA_W  macro read data
nvr_rdy  in  1  macro ready, asynchronous to clk
busy  out  1  state != IDLE

Behaviour:
- Reset (asserted): state=POR_ON; FIFO emptied; all outputs 0 (nvr_a=0, nvr_ce=0, nvr_por=0, req_ready=0, rsp_*=0, busy=1). nvr_ce falls immediately because the reset is asynchronous.
- Reset asserted mid-access aborts the access, and the POR sequence reruns after release.
- nvr_rdy passes through a 2-flop synchroniser (rdy_s). All decisions use rdy_s.
- States:
  - POR_ON: nvr_por=1 for POR_CYCLES cycles starting at the first edge after reset release.
  - POR_WAIT: nvr_por=0 for POR_CYCLES cycles, then go to IDLE.
  - IDLE: req_ready = (fifo_count < FIFO_DEPTH) && !flush. On accept (edge E0), latch req_addr into nvr_a and go to SETUP.
  - SETUP: nvr_ce=0 for SETUP_CYCLES cycles, then go to CE_ON.
  - CE_ON: nvr_ce=1 for CE_CYCLES cycles, then go to WAIT_RDY.
  - WAIT_RDY: nvr_ce=0. On an edge where rdy_s=1, push {nvr_dout, nvr_a, err=0} and go to IDLE. If TIMEOUT cycles elapse without rdy_s, push {0, nvr_a, err=1} and go to IDLE.
- Latency: with nvr_rdy held 1, the push occurs at edge E(SETUP_CYCLES+CE_CYCLES+1), so rsp_valid is high after E5 with the defaults.
- A timeout push occurs at edge E(SETUP_CYCLES+CE_CYCLES+TIMEOUT).
- nvr_a holds its value from accept until the next accept. It is never changed while nvr_ce=1.
- Only one access is in flight at a time. Space is guaranteed because accept requires fifo_count<FIFO_DEPTH, so no push is ever dropped for full.
- FIFO:
  - First-word fall-through: rsp_* show the head combinationally from storage.
  - Pointer wrap is modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.
  - A simultaneous push and pop keeps the count unchanged.
  - A pop on an empty FIFO is ignored.
- flush:
  - On a flush edge the FIFO is emptied (a same-cycle pop is irrelevant).
  - If an access is in flight, the macro timing completes unaltered, but its result is not pushed (a drop flag is set and cleared on return to IDLE).
  - req_ready=0 during any flush cycle.
  - flush during POR states only empties the FIFO.

Test Plan:
- Release reset at t0 -> nvr_por=1 for exactly 4 cycles, 0 for 4 cycles, then req_ready=1; nvr_ce stays 0 throughout.
- nvr_rdy tied 1, preload macro word 5=32'hDEADBEEF, request addr 5 -> nvr_ce high for exactly 2 cycles after 2 setup cycles; rsp_valid at E5 with rsp_data=32'hDEADBEEF, rsp_addr=5, rsp_err=0.
- rsp_ready=0, issue 3 requests (addr 1,2,3) -> the first two complete, req_ready stays 0 afterwards, the third is not accepted. Then pop with rsp_ready=1 -> responses 1,2 pop in order, then the third request is accepted and returns addr 3.
- Hold nvr_rdy=0 after a request to addr 9 -> rsp_err=1, rsp_data=0, rsp_addr=9 at edge E(2+2+255). With nvr_rdy=0 held, the next request also times out; with nvr_rdy=1, it returns data.
- Assert flush for one cycle while in CE_ON with one entry buffered -> FIFO empty, no response for the in-flight access, nvr_ce pulse still 2 cycles wide, the next request returns correctly.
- Assert reset during CE_ON -> nvr_ce=0 immediately, rsp_valid=0, and the full POR sequence repeats after release.
